// File: rtl/ps2_dec_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 decoder.
package ps2_dec_pkg;

  localparam int unsigned KEY_CODE_W     = 9;
  localparam int unsigned SKIP_CNT_W     = 3;
  localparam int unsigned DOWN_CNT_W     = 10;
  localparam int unsigned PAUSE_SKIP_LEN = 7;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_MAX_NORMAL = 8'h83;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REL,
    ST_EXT,
    ST_EXT_REL,
    ST_PAUSE_SKIP
  } dec_state_t;

  typedef struct packed {
    logic                  make;
    logic [KEY_CODE_W-1:0] code;
  } kbd_evt_t;

  // Byte that names a key (as opposed to a prefix or a controller reply)
  function automatic logic is_normal(input logic [7:0] b);
    return (b >= 8'h01) && (b <= PS2_MAX_NORMAL);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Event FIFO for decoded key events: registered storage, count and sticky overflow.
module kbd_evt_fifo
  import ps2_dec_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_push,
  input  kbd_evt_t                 i_evt,
  input  logic                     i_pop,
  input  logic                     i_ovf_clr,
  output logic                     o_valid,
  output kbd_evt_t                 o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  kbd_evt_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_full;
  logic            w_do_pop;
  logic            w_do_push;

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push+pop
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_evt;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (i_push && !w_do_push) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_valid    = (r_count != '0);
  assign o_head     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 sequence decoder with event FIFO and pressed-key bitmap.
// Build option SUPPRESS_REPEAT_EN: drop typematic repeat makes of keys already held.
module ps2_scan_decoder
  import ps2_dec_pkg::*;
#(
  parameter int unsigned               FIFO_DEPTH = 8,
  parameter logic [KEY_CODE_W-1:0]     PAUSE_CODE = 9'h1E1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         din_new,
  input  logic [7:0]                   din,
  input  logic                         evt_rd,
  input  logic                         ovf_clr,
  input  logic [KEY_CODE_W-1:0]        query_code,
  output logic                         evt_valid,
  output logic [KEY_CODE_W-1:0]        evt_code,
  output logic                         evt_make,
  output logic [$clog2(FIFO_DEPTH):0]  evt_count,
  output logic                         overflow,
  output logic                         key_down,
  output logic                         any_key_down
);

  localparam int unsigned NUM_KEYS = 1 << KEY_CODE_W;

  dec_state_t              r_state;
  logic [SKIP_CNT_W-1:0]   r_skip_cnt;
  logic [NUM_KEYS-1:0]     r_bitmap;
  logic [DOWN_CNT_W-1:0]   r_down_cnt;

  logic                    w_is_normal;
  logic                    w_emit;
  logic                    w_make;
  logic                    w_pause;
  logic [KEY_CODE_W-1:0]   w_code;
  logic                    w_bit_old;
  logic                    w_push;
  kbd_evt_t                w_push_evt;
  kbd_evt_t                w_head;

  // Event produced by the byte sampled on this edge
  always_comb begin
    w_is_normal = is_normal(din);
    w_emit      = 1'b0;
    w_make      = 1'b0;
    w_pause     = 1'b0;
    w_code      = '0;
    if (din_new) begin
      case (r_state)
        ST_IDLE: if (w_is_normal) begin
          w_emit = 1'b1;
          w_make = 1'b1;
          w_code = {1'b0, din};
        end
        ST_REL: if (w_is_normal) begin
          w_emit = 1'b1;
          w_code = {1'b0, din};
        end
        ST_EXT: if (w_is_normal) begin
          w_emit = 1'b1;
          w_make = 1'b1;
          w_code = {1'b1, din};
        end
        ST_EXT_REL: if (w_is_normal) begin
          w_emit = 1'b1;
          w_code = {1'b1, din};
        end
        ST_PAUSE_SKIP: if (r_skip_cnt == SKIP_CNT_W'(1)) begin
          w_emit  = 1'b1;
          w_make  = 1'b1;
          w_pause = 1'b1;
          w_code  = PAUSE_CODE;
        end
        default: ;
      endcase
    end
    w_bit_old = r_bitmap[w_code];
`ifdef SUPPRESS_REPEAT_EN
    w_push = w_emit && !(w_make && w_bit_old && !w_pause);
`else
    w_push = w_emit;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else if (din_new) begin
      case (r_state)
        ST_IDLE: begin
          if (din == PS2_REL) begin
            r_state <= ST_REL;
          end else if (din == PS2_EXT) begin
            r_state <= ST_EXT;
          end else if (din == PS2_PAUSE) begin
            r_state    <= ST_PAUSE_SKIP;
            r_skip_cnt <= SKIP_CNT_W'(PAUSE_SKIP_LEN);
          end
        end
        ST_EXT:        r_state <= (din == PS2_REL) ? ST_EXT_REL : ST_IDLE;
        ST_PAUSE_SKIP: begin
          r_skip_cnt <= r_skip_cnt - SKIP_CNT_W'(1);
          if (r_skip_cnt == SKIP_CNT_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default:       r_state <= ST_IDLE;
      endcase
    end
  end

  // Held-key tracking; the counter only moves on real bit transitions
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bitmap   <= '0;
      r_down_cnt <= '0;
    end else if (w_emit && !w_pause) begin
      r_bitmap[w_code] <= w_make;
      if (w_make && !w_bit_old) begin
        r_down_cnt <= r_down_cnt + DOWN_CNT_W'(1);
      end else if (!w_make && w_bit_old) begin
        r_down_cnt <= r_down_cnt - DOWN_CNT_W'(1);
      end
    end
  end

  assign w_push_evt.make = w_make;
  assign w_push_evt.code = w_code;

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetN     (resetN),
    .i_push     (w_push),
    .i_evt      (w_push_evt),
    .i_pop      (evt_rd),
    .i_ovf_clr  (ovf_clr),
    .o_valid    (evt_valid),
    .o_head     (w_head),
    .o_count    (evt_count),
    .o_overflow (overflow)
  );

  assign evt_code     = w_head.code;
  assign evt_make     = w_head.make;
  assign key_down     = r_bitmap[query_code];
  assign any_key_down = (r_down_cnt != '0);

endmodule
